// File: rtl/core_sequencer_pkg.sv
// Shared definitions for the core sequencer: PC width, opcodes, FSM states.
// SEQ_SINGLE_STEP_EN adds the HOLD state used while waiting for a step pulse.
package core_sequencer_pkg;

    localparam int PC_WIDTH = 16;

    typedef enum logic [3:0] {
        NOP = 4'd0,
        INC = 4'd1,
        DEC = 4'd2,
        MVR = 4'd3,
        MVL = 4'd4,
        PSH = 4'd5,
        POP = 4'd6,
        CBF = 4'd7,
        CBB = 4'd8
    } op_code;

`ifdef SEQ_SINGLE_STEP_EN
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT, HOLD} seq_state;
`else
    typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} seq_state;
`endif

    // Every opcode except NOP touches data memory before it can commit.
    function automatic logic op_needs_mem(input op_code op);
        case (op)
            INC, DEC, PSH, POP, MVR, MVL, CBF, CBB: return 1'b1;
            default:                               return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/core_sequencer_pc_counter.sv
// Program counter register with synchronous clear and increment (wraps modulo 2^PC_WIDTH).
module pc_counter
    import core_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                clear,
    input  logic                incr,
    output logic [PC_WIDTH-1:0] pc
);

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            pc <= '0;
        end else if (incr) begin
            pc <= pc + PC_WIDTH'(1);
        end
    end

endmodule

// File: rtl/core_sequencer.sv
// Fetch/execute sequencer issuing one commit strobe per instruction to core_control.
// Optional SEQ_SINGLE_STEP_EN adds a step input that gates every launch into FETCH.
module core_sequencer
    import core_sequencer_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic                halt_req,
    input  logic [PC_WIDTH-1:0] prog_len,
    input  logic                imem_ack,
    input  op_code              instr,
    input  logic                dmem_ack,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                step,
`endif
    output logic [PC_WIDTH-1:0] pc,
    output op_code              ir,
    output logic                imem_req,
    output logic                dmem_req,
    output logic                commit_en,
    output logic                busy,
    output logic                done
);

    seq_state            state, state_n, run_n, launch_n, boundary_n;
    logic [PC_WIDTH-1:0] pc_plus1;
    logic                pc_clr, pc_inc, ir_load, commit;

    pc_counter u_pc (
        .clock (clock),
        .reset (reset),
        .clear (pc_clr),
        .incr  (pc_inc),
        .pc    (pc)
    );

`ifdef SEQ_SINGLE_STEP_EN
    assign run_n = step ? FETCH : HOLD;
    assign busy  = (state == FETCH) || (state == EXEC) || (state == MEM) || (state == HOLD);
`else
    assign run_n = FETCH;
    assign busy  = (state == FETCH) || (state == EXEC) || (state == MEM);
`endif

    // The boundary test looks at the pc value the committing instruction is about to write.
    assign pc_plus1   = pc + PC_WIDTH'(1);
    assign boundary_n = ((pc_plus1 == prog_len) || halt_req) ? HALT : run_n;
    assign launch_n   = (prog_len == '0) ? HALT : run_n;
    assign done       = (state == HALT);
    assign commit_en  = commit & ~reset;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ir <= NOP;
        end else if (ir_load) begin
            ir <= instr;
        end
    end

    always_comb begin
        state_n  = state;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        commit   = 1'b0;
        pc_clr   = 1'b0;
        pc_inc   = 1'b0;
        ir_load  = 1'b0;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_clr  = 1'b1;
                    state_n = launch_n;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (op_needs_mem(ir)) begin
                    state_n = MEM;
                end else begin
                    commit  = 1'b1;
                    pc_inc  = 1'b1;
                    state_n = boundary_n;
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    commit  = 1'b1;
                    pc_inc  = 1'b1;
                    state_n = boundary_n;
                end
            end
`ifdef SEQ_SINGLE_STEP_EN
            HOLD: begin
                if (halt_req) begin
                    state_n = HALT;
                end else if (step) begin
                    state_n = FETCH;
                end
            end
`endif
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: directed table, reset corner and randomized programs.
module tb_core_sequencer;
    import core_sequencer_pkg::*;

    logic                clock = 1'b0;
    logic                reset, start, halt_req, imem_ack, dmem_ack;
    logic [PC_WIDTH-1:0] prog_len, pc;
    op_code              instr, ir;
    logic                imem_req, dmem_req, commit_en, busy, done;
`ifdef SEQ_SINGLE_STEP_EN
    logic                step;
`endif

    core_sequencer dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .halt_req  (halt_req),
        .prog_len  (prog_len),
        .imem_ack  (imem_ack),
        .instr     (instr),
        .dmem_ack  (dmem_ack),
`ifdef SEQ_SINGLE_STEP_EN
        .step      (step),
`endif
        .pc        (pc),
        .ir        (ir),
        .imem_req  (imem_req),
        .dmem_req  (dmem_req),
        .commit_en (commit_en),
        .busy      (busy),
        .done      (done)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Program image and per-instruction memory wait states seen by the responder.
    op_code prog [16];
    int     idly [16];
    int     ddly [16];
    int     halt_at = -1;

    int     icnt = 0, dcnt = 0;
    int     commit_cyc [$];
    int     commit_pc [$];
    op_code commit_ir [$];
    int     imem_run = 0, dmem_run = 0, imem_max = 0, dmem_max = 0;
    int     both_hi = 0, stray = 0;
    int     start_cyc, done_rel;
    bit     timed_out;

    int     errors = 0;
    int     checks = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Memory responder drives inputs on the falling edge, then the monitor samples mid-low-phase.
    always @(negedge clock) begin
        instr    = prog[pc[3:0]];
        halt_req = (halt_at >= 0) && busy && (int'(pc) == halt_at);
        if (imem_req) begin
            imem_ack = (icnt == idly[pc[3:0]]);
            icnt     = imem_ack ? 0 : icnt + 1;
        end else begin
            imem_ack = 1'b0;
            icnt     = 0;
        end
        if (dmem_req) begin
            dmem_ack = (dcnt == ddly[pc[3:0]]);
            dcnt     = dmem_ack ? 0 : dcnt + 1;
        end else begin
            dmem_ack = 1'b0;
            dcnt     = 0;
        end
        #2;
        if (commit_en) begin
            commit_cyc.push_back(cyc);
            commit_pc.push_back(int'(pc));
            commit_ir.push_back(ir);
        end
        imem_run = imem_req ? imem_run + 1 : 0;
        dmem_run = dmem_req ? dmem_run + 1 : 0;
        if (imem_run > imem_max) imem_max = imem_run;
        if (dmem_run > dmem_max) dmem_max = dmem_run;
        if (imem_req && dmem_req) both_hi++;
        if (commit_en && !busy) stray++;
    end

    task automatic clear_obs();
        commit_cyc.delete();
        commit_pc.delete();
        commit_ir.delete();
        imem_max = 0;
        dmem_max = 0;
        both_hi  = 0;
        stray    = 0;
    endtask

    task automatic run_case(input int len, input bit noise);
        clear_obs();
        prog_len = PC_WIDTH'(len);
        @(negedge clock);
        start     = 1'b1;
        start_cyc = cyc;
        @(negedge clock);
        start     = 1'b0;
        timed_out = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin
                timed_out = 1'b0;
                break;
            end
            start = noise && busy && ($urandom_range(0, 5) == 0);
            @(negedge clock);
        end
        start    = 1'b0;
        done_rel = cyc - start_cyc;
        #3;
    endtask

    typedef struct packed {
        int     len;
        op_code p0, p1, p2, p3, p4;
        int     idl, ddl, halt;
        int     ncom, epc, efirst, elast, edone, imax, dmax;
    } vec_t;

    vec_t vecs [6];

    initial begin
        reset = 1'b1; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
        prog_len = '0;
`ifdef SEQ_SINGLE_STEP_EN
        step = 1'b1;
`endif
        for (int k = 0; k < 16; k++) begin
            prog[k] = NOP; idly[k] = 0; ddly[k] = 0;
        end

        //            len  p0   p1   p2   p3   p4   idl ddl halt ncom pc first last done imax dmax
        vecs[0] = '{  3,  INC, NOP, PSH, NOP, NOP, 0,  0,  -1,  3,   3, 3,    8,   9,   1,   1};
        vecs[1] = '{  0,  NOP, NOP, NOP, NOP, NOP, 0,  0,  -1,  0,   0, 0,    0,   1,   0,   0};
        vecs[2] = '{  1,  DEC, NOP, NOP, NOP, NOP, 4,  2,  -1,  1,   1, 9,    9,   10,  5,   3};
        vecs[3] = '{  5,  INC, NOP, PSH, POP, MVR, 0,  0,  0,   1,   1, 3,    3,   4,   1,   1};
        vecs[4] = '{  2,  NOP, NOP, NOP, NOP, NOP, 0,  0,  -1,  2,   2, 2,    4,   5,   1,   0};
        vecs[5] = '{  4,  CBF, MVL, NOP, CBB, NOP, 1,  1,  2,   3,   3, 5,    13,  14,  2,   2};

        repeat (3) @(negedge clock);
        reset = 1'b0;
        #3;
        check("rst_pc", int'(pc), 0);
        check("rst_ir", int'(ir), int'(NOP));
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_imem_req", int'(imem_req), 0);
        check("rst_dmem_req", int'(dmem_req), 0);
        check("rst_commit", int'(commit_en), 0);

        for (int v = 0; v < 6; v++) begin
            prog[0] = vecs[v].p0; prog[1] = vecs[v].p1; prog[2] = vecs[v].p2;
            prog[3] = vecs[v].p3; prog[4] = vecs[v].p4;
            for (int k = 0; k < 16; k++) begin
                idly[k] = vecs[v].idl;
                ddly[k] = vecs[v].ddl;
            end
            halt_at = vecs[v].halt;
            run_case(vecs[v].len, 1'b0);
            check($sformatf("vec%0d_timeout", v), int'(timed_out), 0);
            check($sformatf("vec%0d_commits", v), commit_cyc.size(), vecs[v].ncom);
            if (vecs[v].ncom > 0 && commit_cyc.size() > 0) begin
                check($sformatf("vec%0d_first", v), commit_cyc[0] - start_cyc, vecs[v].efirst);
                check($sformatf("vec%0d_last", v), commit_cyc[$] - start_cyc, vecs[v].elast);
            end
            check($sformatf("vec%0d_pc", v), int'(pc), vecs[v].epc);
            check($sformatf("vec%0d_done_cyc", v), done_rel, vecs[v].edone);
            check($sformatf("vec%0d_imem_hold", v), imem_max, vecs[v].imax);
            check($sformatf("vec%0d_dmem_hold", v), dmem_max, vecs[v].dmax);
            check($sformatf("vec%0d_req_overlap", v), both_hi, 0);
            check($sformatf("vec%0d_stray_commit", v), stray, 0);
        end

        // Reset landing on the very cycle the data memory acknowledges.
        halt_at = -1;
        prog[0] = DEC; idly[0] = 0; ddly[0] = 3;
        clear_obs();
        prog_len = PC_WIDTH'(1);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (5) @(negedge clock);
        reset = 1'b1;
        #3;
        check("rstmem_dmem_req_before", int'(dmem_req), 1);
        check("rstmem_commit_in_reset", int'(commit_en), 0);
        @(negedge clock);
        reset = 1'b0;
        #3;
        check("rstmem_busy", int'(busy), 0);
        check("rstmem_done", int'(done), 0);
        check("rstmem_dmem_req", int'(dmem_req), 0);
        check("rstmem_pc", int'(pc), 0);
        check("rstmem_ir", int'(ir), int'(NOP));
        check("rstmem_commits", commit_cyc.size(), 0);

        // Randomized programs checked against an instruction-level timing model.
        for (int r = 0; r < 25; r++) begin
            int len, exp_n, t;
            len = int'($urandom_range(1, 8));
            for (int k = 0; k < 16; k++) begin
                prog[k] = op_code'(4'($urandom_range(0, 8)));
                idly[k] = int'($urandom_range(0, 3));
                ddly[k] = int'($urandom_range(0, 3));
            end
            halt_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_case(len, 1'b1);
            exp_n = (halt_at >= 0) ? halt_at + 1 : len;
            check($sformatf("rnd%0d_timeout", r), int'(timed_out), 0);
            check($sformatf("rnd%0d_commits", r), commit_cyc.size(), exp_n);
            t = start_cyc;
            for (int k = 0; k < exp_n; k++) begin
                t += idly[k] + 2;
                if (prog[k] inside {INC, DEC, PSH, POP, MVR, MVL, CBF, CBB}) t += ddly[k] + 1;
                if (k < commit_cyc.size()) begin
                    check($sformatf("rnd%0d_c%0d_cyc", r, k), commit_cyc[k], t);
                    check($sformatf("rnd%0d_c%0d_pc", r, k), commit_pc[k], k);
                    check($sformatf("rnd%0d_c%0d_ir", r, k), int'(commit_ir[k]), int'(prog[k]));
                end
            end
            check($sformatf("rnd%0d_pc", r), int'(pc), exp_n);
            check($sformatf("rnd%0d_ir", r), int'(ir), int'(prog[exp_n - 1]));
            check($sformatf("rnd%0d_done_cyc", r), done_rel, t - start_cyc + 1);
            check($sformatf("rnd%0d_req_overlap", r), both_hi, 0);
            check($sformatf("rnd%0d_stray_commit", r), stray, 0);
        end

`ifdef SEQ_SINGLE_STEP_EN
        // Single stepping: one committed instruction per step pulse.
        halt_at = -1;
        prog[0] = NOP; prog[1] = NOP;
        for (int k = 0; k < 16; k++) begin
            idly[k] = 0; ddly[k] = 0;
        end
        step = 1'b0;
        clear_obs();
        prog_len = PC_WIDTH'(2);
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        #3;
        check("step_wait_busy", int'(busy), 1);
        check("step_wait_imem", int'(imem_req), 0);
        check("step_wait_commits", commit_cyc.size(), 0);
        for (int s = 0; s < 2; s++) begin
            @(negedge clock);
            step = 1'b1;
            @(negedge clock);
            step = 1'b0;
            repeat (8) @(negedge clock);
            #3;
            check($sformatf("step%0d_commits", s), commit_cyc.size(), s + 1);
            check($sformatf("step%0d_done", s), int'(done), s);
        end
        check("step_pc", int'(pc), 2);
        step = 1'b1;
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
